fetch_stage_32: RTL and testbench

Instruction fetch stage of the 32-bit MIPS core. It owns the program counter and the instruction-memory request handshake. It applies branch/jump redirects and handles hazard stalls, and registers each fetched instruction with its PC+4 into the IF/ID pipeline register. Its opcode output drives the main control decoder's `instruction_special` input, and its funct output feeds ALU control.

---
 rtl/mips32_pkg.sv | 34 +++
 rtl/fetch_stage_32_if.sv | 15 +
 rtl/ifid_reg_32.sv | 34 +++
 rtl/fetch_stage_32.sv | 139 +++++++++++++
 tb/tb_fetch_stage_32.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 core definitions: fetch FSM states, IF/ID payload, reset PC,
// NOP and the primary opcode values the control decoder also uses.
package mips32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    S_START    = 2'd0,
    S_FETCH    = 2'd1,
    S_BUFFERED = 2'd2,
    S_DRAIN    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } ifid_payload_t;

  // Instruction addresses are word aligned; low bits of targets are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_32_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_32_if;
  import mips32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifid_reg_32.sv
// IF/ID pipeline register: load captures a fetched word, flush kills the
// valid bit, otherwise contents hold.
module ifid_reg_32
  import mips32_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          flush_i,
  input  ifid_payload_t data_i,
  output logic          valid_o,
  output ifid_payload_t data_o
);

  logic          valid_q;
  ifid_payload_t data_q;

  // Flush wins so a redirect can never be overridden by a same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '{instr: NOP_WORD, pc4: '0};
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage_32.sv
// MIPS32 instruction fetch: owns the PC and imem handshake, applies
// redirects, absorbs hazard stalls and feeds the IF/ID register.
module fetch_stage_32
  import mips32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             reset_n,
  fetch_stage_32_if.master imem,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             ifid_valid,
  output logic [XLEN-1:0]  ifid_instr,
  output logic [XLEN-1:0]  ifid_pc4,
  output logic [OPW-1:0]   opcode,
  output logic [OPW-1:0]   funct
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ifid_payload_t   buf_q, buf_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            ifid_load;
  logic            ifid_flush;
  ifid_payload_t   ifid_din;
  ifid_payload_t   ifid_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_tgt;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign redir_tgt = word_align(redirect_pc);

  // Next-state, PC and IF/ID control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    redir_d    = redir_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_din   = '{instr: imem.imem_rdata, pc4: pc_plus4};

    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_d = redir_tgt;
          end else begin
            redir_d = redir_tgt;
            state_d = S_DRAIN;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_plus4;
          if (!stall || !ifid_valid) begin
            ifid_load = 1'b1;
          end else begin
            buf_d   = ifid_din;
            state_d = S_BUFFERED;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      S_BUFFERED: begin
        ifid_din = buf_q;
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          pc_d       = redir_tgt;
          state_d    = S_FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          redir_d    = redir_tgt;
        end
        // The stale request must complete before the target can be issued.
        if (imem.imem_ready) begin
          pc_d    = redirect_valid ? redir_tgt : redir_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_START;
    endcase

    req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
    addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      buf_q   <= '{instr: NOP_WORD, pc4: '0};
      redir_q <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  ifid_reg_32 u_ifid (
    .clk     (clk),
    .rst_n   (reset_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .data_i  (ifid_din),
    .valid_o (ifid_valid),
    .data_o  (ifid_q)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc4       = ifid_q.pc4;
  assign opcode         = ifid_q.instr[31:26];
  assign funct          = ifid_q.instr[5:0];

endmodule

// File: tb/tb_fetch_stage_32.sv
// Bench for fetch_stage_32: directed scenarios, then random ready/stall/redirect
// traffic scored against an in-order instruction-stream model.
`timescale 1ns/1ps
module tb_fetch_stage_32;
  import mips32_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  fetch_stage_32_if imem_bus ();

  fetch_stage_32 #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem           (imem_bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .opcode         (opcode),
    .funct          (funct)
  );

  always #5 clk = ~clk;

  // Program image: two known words at 0 and 4, a hash everywhere else.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h0022_1020;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign imem_bus.imem_rdata = imem_bus.imem_ready ? instr_at(imem_bus.imem_addr)
                                                   : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model: every instruction decode takes must be the next sequential
  // word, restarting at the target of the latest redirect.
  logic [31:0] exp_pc;
  logic [31:0] exp_word;
  bit          have_prev;
  logic        p_req, p_ready, p_stall, p_redir, p_valid;
  logic [31:0] p_addr, p_instr, p_pc4;

  initial begin
    have_prev = 1'b0;
    exp_pc    = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_pc    = 32'h0;
        have_prev = 1'b0;
      end else begin
        if (have_prev && p_req && !p_ready) begin
          chk("hs_req_held", 32'(imem_bus.imem_req), 1);
          chk("hs_addr_stable", imem_bus.imem_addr, p_addr);
        end
        if (have_prev && p_stall && !p_redir && p_valid) begin
          chk("stall_valid", 32'(ifid_valid), 1);
          chk("stall_instr", ifid_instr, p_instr);
          chk("stall_pc4", ifid_pc4, p_pc4);
        end
        if (imem_bus.imem_req)
          chk("addr_align", 32'(imem_bus.imem_addr[1:0]), 0);
        if (redirect_valid) begin
          exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (ifid_valid && !stall) begin
          exp_word = instr_at(exp_pc);
          chk("sb_instr", ifid_instr, exp_word);
          chk("sb_pc4", ifid_pc4, exp_pc + 32'd4);
          chk("sb_opcode", 32'(opcode), 32'(exp_word[31:26]));
          chk("sb_funct", 32'(funct), 32'(exp_word[5:0]));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        p_req   = imem_bus.imem_req;
        p_ready = imem_bus.imem_ready;
        p_stall = stall;
        p_redir = redirect_valid;
        p_valid = ifid_valid;
        p_addr  = imem_bus.imem_addr;
        p_instr = ifid_instr;
        p_pc4   = ifid_pc4;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_bus.imem_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(ifid_valid), 0);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pc4", ifid_pc4, 0);
    chk("rst_req", 32'(imem_bus.imem_req), 0);
    chk("rst_addr", imem_bus.imem_addr, 0);

    // Zero-wait fetch after reset.
    tick(); reset_n = 1'b1; imem_bus.imem_ready = 1'b1;
    chk("c1_req", 32'(imem_bus.imem_req), 0);
    tick();
    chk("c2_req", 32'(imem_bus.imem_req), 1);
    chk("c2_addr", imem_bus.imem_addr, 32'h0);
    tick();
    chk("c3_valid", 32'(ifid_valid), 1);
    chk("c3_instr", ifid_instr, 32'h8C01_0004);
    chk("c3_pc4", ifid_pc4, 32'h4);
    chk("c3_opcode", 32'(opcode), 32'h23);
    tick();
    chk("c4_instr", ifid_instr, 32'h0022_1020);
    chk("c4_funct", 32'(funct), 32'h20);
    chk("c4_addr", imem_bus.imem_addr, 32'h8);

    // Redirect during zero-wait fetch of 0x8.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); redirect_valid = 1'b0;
    chk("rd_valid", 32'(ifid_valid), 0);
    chk("rd_addr", imem_bus.imem_addr, 32'h40);
    tick();
    chk("rd_tgt_valid", 32'(ifid_valid), 1);
    chk("rd_tgt_pc4", ifid_pc4, 32'h44);

    // Three-cycle stall while a fetch completes.
    tick(); stall = 1'b1;
    chk("st0_pc4", ifid_pc4, 32'h48);
    tick();
    chk("st1_req", 32'(imem_bus.imem_req), 0);
    chk("st1_pc4", ifid_pc4, 32'h48);
    tick();
    chk("st2_req", 32'(imem_bus.imem_req), 0);
    tick(); stall = 1'b0;
    chk("st3_pc4", ifid_pc4, 32'h48);
    tick();
    chk("st_buf_pc4", ifid_pc4, 32'h4C);
    chk("st_buf_instr", ifid_instr, instr_at(32'h48));
    chk("st_resume_addr", imem_bus.imem_addr, 32'h4C);
    tick();
    chk("st_next_pc4", ifid_pc4, 32'h50);

    // Slow memory with redirect to 0x100 in the first wait cycle.
    tick(); imem_bus.imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    chk("dr_addr0", imem_bus.imem_addr, 32'h54);
    for (int i = 0; i < 3; i++) begin
      tick(); redirect_valid = 1'b0;
      chk("dr_addr_hold", imem_bus.imem_addr, 32'h54);
      chk("dr_req_hold", 32'(imem_bus.imem_req), 1);
      chk("dr_valid", 32'(ifid_valid), 0);
    end
    tick(); imem_bus.imem_ready = 1'b1;
    chk("dr_addr_last", imem_bus.imem_addr, 32'h54);
    tick();
    chk("dr_tgt_addr", imem_bus.imem_addr, 32'h100);
    chk("dr_not_loaded", 32'(ifid_valid), 0);
    tick();
    chk("dr_tgt_pc4", ifid_pc4, 32'h104);

    // Stall plus redirect while buffered.
    tick(); stall = 1'b1;
    chk("bf_pc4", ifid_pc4, 32'h108);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    chk("bf_req", 32'(imem_bus.imem_req), 0);
    tick(); stall = 1'b0; redirect_valid = 1'b0;
    chk("bf_flush_valid", 32'(ifid_valid), 0);
    chk("bf_tgt_addr", imem_bus.imem_addr, 32'h200);
    tick();
    chk("bf_tgt_pc4", ifid_pc4, 32'h204);

    // PC wrap; low target bits must be ignored.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); redirect_valid = 1'b0;
    chk("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc4", ifid_pc4, 32'h0);
    chk("wr_next_addr", imem_bus.imem_addr, 32'h0);

    // Reset in the middle of a drain.
    tick(); imem_bus.imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick(); redirect_valid = 1'b0;
    chk("md_req", 32'(imem_bus.imem_req), 1);
    chk("md_addr", imem_bus.imem_addr, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", 32'(imem_bus.imem_req), 0);
    chk("ar_addr", imem_bus.imem_addr, 0);
    chk("ar_valid", 32'(ifid_valid), 0);
    chk("ar_instr", ifid_instr, 0);
    chk("ar_pc4", ifid_pc4, 0);
    tick(); tick();
    tick(); reset_n = 1'b1; imem_bus.imem_ready = 1'b1;
    chk("r2_c1_req", 32'(imem_bus.imem_req), 0);
    tick();
    chk("r2_c2_req", 32'(imem_bus.imem_req), 1);
    chk("r2_c2_addr", imem_bus.imem_addr, 0);

    // Random traffic scored by the stream model.
    for (int n = 0; n < 2000; n++) begin
      tick();
      imem_bus.imem_ready = ($urandom_range(0, 3) != 0);
      stall               = ($urandom_range(0, 3) == 0);
      redirect_valid      = ($urandom_range(0, 24) == 0);
      redirect_pc         = $urandom;
    end
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("progress", 32'(consumed > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
